universal_shift_burst_reg: RTL and testbench
============================================

Name: universal_shift_burst_reg

Overview:
Parametrised successor to the 8-bit left/right load shift register. It has WIDTH-bit storage, parallel load, and six shift/rotate modes with serial fill inputs. Shifting runs either one step per cycle while shift_en is high, or as a counted burst started by start/amount with busy/done handshake. It serves as a generic serialiser and barrel-by-iteration element for datapath and peripheral blocks.

Parameters:
WIDTH, 8, register width (>= 2)
RESET_VAL, 0, value of q after reset (WIDTH bits)
CNT_W (localparam), $clog2(WIDTH+1), width of amount/remaining counter

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
d  in  WIDTH  parallel load data
load  in  1  parallel load, highest priority
mode  in  3  operation select (see Behaviour)
ser_in_l  in  1  fill bit entering at LSB on SHL
ser_in_r  in  1  fill bit entering at MSB on SHR
shift_en  in  1  single-step shift every cycle while high (IDLE only)
start  in  1  begin burst of amount shifts (IDLE only)
amount  in  CNT_W  number of shifts in burst
q  out  WIDTH  register contents
ser_out  out  1  bit most recently shifted/rotated out
busy  out  1  burst in progress
done  out  1  one-cycle pulse, burst complete

Behaviour:
- Reset (async, reset_n=0): q=RESET_VAL, ser_out=0, busy=0, done=0, rem=0, state=IDLE. Reset mid-burst aborts it; no done.
- Modes: 000 HOLD. 001 SHL: q<={q[W-2:0],ser_in_l}, out=q[W-1]. 010 SHR: q<={ser_in_r,q[W-1:1]}, out=q[0]. 011 ROL, out=q[W-1]. 100 ROR, out=q[0]. 101 ASR: fill q[W-1], out=q[0]. 110/111 reserved, treated as HOLD.
- ser_out updates only on a shifting edge (not HOLD, not load); it otherwise holds.
- States: IDLE, RUN. The mode is latched into mode_r at start. Serial fill inputs are sampled live on every shift edge.
- Priority per edge: load > RUN step > start > shift_en > hold.
- load=1: q<=d. In RUN, load aborts the burst: state->IDLE, busy=0, no done. ser_out unchanged.
- IDLE, start=1, amount>=1: first shift occurs on this same edge using mode. rem<=amount-1.
  - If amount==1: done=1 on this edge and state stays IDLE.
  - Else: busy=1 and state->RUN.
- IDLE, start=1, amount==0: no shift, done=1 on this edge, busy stays 0.
- RUN, each edge: shift with mode_r, rem<=rem-1. When rem==1 at the edge: busy<=0, done<=1, ->IDLE. Total shifts equal amount exactly; q is final on the edge done rises.
- start or shift_en while busy: ignored. Changing mode during RUN has no effect.
- IDLE, shift_en=1, start=0: one shift per cycle with live mode. done and busy stay 0.
- done is high for exactly one cycle per completed burst. A new start is accepted on the cycle done is high, since state is IDLE.
- amount>WIDTH is legal: shifts iterate, rotates wrap modulo WIDTH, and logical shifts fully fill with serial inputs.

Decomposition:
- Package shift_pkg: mode localparams (MODE_HOLD..MODE_ASR), state encoding (ST_IDLE, ST_RUN).
- Sub-module shift_step (combinational, parameter WIDTH): inputs q, mode, ser_in_l, ser_in_r; outputs next_q and out_bit. It is instantiated once, with its mode input muxed between mode and mode_r.
- Top level contains the FSM, counter, load/priority and output registers.

Test Plan:
- Reset then load d=8'hFF; start SHL amount=3, ser_in_l=0 -> q=8'hF8 on 3rd shift edge, busy high 2 cycles, done 1-cycle pulse, ser_out=1.
- Load 8'hA8; ROR amount=8 -> q returns to 8'hA8, done once. ASR amount=3 on 8'h80 -> q=8'hF0, ser_out=0.
- start amount=0 on q=8'h5A -> done pulses on that edge, busy never high, q=8'h5A.
- Load mid-burst: SHR amount=6 from 8'hFF, ser_in_r=0, load d=8'h3C on 3rd cycle -> q=8'h3C, busy=0, no done. Separately, reset_n low mid-burst -> q=RESET_VAL, busy=0, done=0 immediately.
- shift_en single-step: q=8'b1010_1000, mode SHR, ser_in_r=1, 5 cycles -> q=8'b1111_1101. start asserted during RUN is ignored (done count stays 1).
- WIDTH=16 instance: ROL amount=4 on 16'h1234 -> 16'h2341; amount=16 SHL with ser_in_l=1 -> 16'hFFFF.

Source files
------------

// File: rtl/universal_shift_burst_reg_pkg.sv
// Shared encodings for the universal shift/burst register: operation modes and FSM states.
package universal_shift_burst_reg_pkg;

  typedef enum logic [2:0] {
    ModeHold = 3'd0,
    ModeShl  = 3'd1,
    ModeShr  = 3'd2,
    ModeRol  = 3'd3,
    ModeRor  = 3'd4,
    ModeAsr  = 3'd5
  } mode_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/universal_shift_burst_reg_shift_step.sv
// One combinational shift/rotate step; shift_o flags modes that actually move bits.
module universal_shift_burst_reg_shift_step
  import universal_shift_burst_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       mode_i,
  input  logic             ser_in_l_i,
  input  logic             ser_in_r_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             out_bit_o,
  output logic             shift_o
);

  always_comb begin
    next_q_o  = q_i;
    out_bit_o = 1'b0;
    shift_o   = 1'b0;
    case (mode_i)
      ModeShl: begin
        next_q_o  = {q_i[WIDTH-2:0], ser_in_l_i};
        out_bit_o = q_i[WIDTH-1];
        shift_o   = 1'b1;
      end
      ModeShr: begin
        next_q_o  = {ser_in_r_i, q_i[WIDTH-1:1]};
        out_bit_o = q_i[0];
        shift_o   = 1'b1;
      end
      ModeRol: begin
        next_q_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        out_bit_o = q_i[WIDTH-1];
        shift_o   = 1'b1;
      end
      ModeRor: begin
        next_q_o  = {q_i[0], q_i[WIDTH-1:1]};
        out_bit_o = q_i[0];
        shift_o   = 1'b1;
      end
      ModeAsr: begin
        next_q_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        out_bit_o = q_i[0];
        shift_o   = 1'b1;
      end
      // Hold and the reserved codes leave q and the serial output untouched.
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_burst_reg.sv
// Universal shift register with parallel load, single-step shifting and counted bursts.
module universal_shift_burst_reg
  import universal_shift_burst_reg_pkg::*;
#(
  parameter int unsigned    WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned   CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] d_i,
  input  logic             load_i,
  input  logic [2:0]       mode_i,
  input  logic             ser_in_l_i,
  input  logic             ser_in_r_i,
  input  logic             shift_en_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] amount_i,
  output logic [WIDTH-1:0] q_o,
  output logic             ser_out_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic             ser_out_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] rem_q;
  logic [2:0]       mode_r_q;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_out;
  logic             step_shift;

  // A running burst keeps its latched mode; otherwise the live mode drives the step.
  assign step_mode = (state_q == StRun) ? mode_r_q : mode_i;

  universal_shift_burst_reg_shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q_i       (q_q),
    .mode_i    (step_mode),
    .ser_in_l_i(ser_in_l_i),
    .ser_in_r_i(ser_in_r_i),
    .next_q_o  (step_q),
    .out_bit_o (step_out),
    .shift_o   (step_shift)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      q_q       <= RESET_VAL;
      ser_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rem_q     <= '0;
      mode_r_q  <= ModeHold;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        q_q <= d_i;
        if (state_q == StRun) begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          rem_q   <= '0;
        end
      end else if (state_q == StRun) begin
        q_q   <= step_q;
        rem_q <= rem_q - CNT_W'(1);
        if (step_shift) begin
          ser_out_q <= step_out;
        end
        if (rem_q == CNT_W'(1)) begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else if (start_i) begin
        if (amount_i == '0) begin
          done_q <= 1'b1;
        end else begin
          // The first shift of the burst lands on the accepting edge.
          q_q      <= step_q;
          mode_r_q <= mode_i;
          rem_q    <= amount_i - CNT_W'(1);
          if (step_shift) begin
            ser_out_q <= step_out;
          end
          if (amount_i == CNT_W'(1)) begin
            done_q <= 1'b1;
          end else begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
      end else if (shift_en_i) begin
        q_q <= step_q;
        if (step_shift) begin
          ser_out_q <= step_out;
        end
      end
    end
  end

  assign q_o       = q_q;
  assign ser_out_o = ser_out_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  busy_done_exclusive: assert property (@(posedge clk_i) disable iff (!reset_ni)
    !(busy_o && done_o));

  busy_tracks_state: assert property (@(posedge clk_i) disable iff (!reset_ni)
    busy_o == (state_q == StRun));

endmodule

// File: tb/tb_universal_shift_burst_reg.sv
// Directed bench for universal_shift_burst_reg: vector table on an 8-bit instance plus
// hand-written reset-abort and 16-bit burst sequences.
module tb_universal_shift_burst_reg;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // 8-bit instance
  logic [7:0] d8, q8;
  logic       ld8, sl8, sr8, sen8, st8, so8, busy8, done8;
  logic [2:0] mode8;
  logic [3:0] amt8;

  // 16-bit instance
  logic [15:0] d16, q16;
  logic        ld16, sl16, sr16, sen16, st16, so16, busy16, done16;
  logic [2:0]  mode16;
  logic [4:0]  amt16;

  universal_shift_burst_reg #(
    .WIDTH    (8),
    .RESET_VAL(8'h00)
  ) u_dut8 (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .d_i       (d8),
    .load_i    (ld8),
    .mode_i    (mode8),
    .ser_in_l_i(sl8),
    .ser_in_r_i(sr8),
    .shift_en_i(sen8),
    .start_i   (st8),
    .amount_i  (amt8),
    .q_o       (q8),
    .ser_out_o (so8),
    .busy_o    (busy8),
    .done_o    (done8)
  );

  universal_shift_burst_reg #(
    .WIDTH    (16),
    .RESET_VAL(16'hBEEF)
  ) u_dut16 (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .d_i       (d16),
    .load_i    (ld16),
    .mode_i    (mode16),
    .ser_in_l_i(sl16),
    .ser_in_r_i(sr16),
    .shift_en_i(sen16),
    .start_i   (st16),
    .amount_i  (amt16),
    .q_o       (q16),
    .ser_out_o (so16),
    .busy_o    (busy16),
    .done_o    (done16)
  );

  typedef struct {
    logic       ld;
    logic [7:0] d;
    logic [2:0] mode;
    logic       sl;
    logic       sr;
    logic       sen;
    logic       st;
    logic [3:0] amt;
    logic [7:0] eq;
    logic       eso;
    logic       eb;
    logic       edn;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [7:0] d, input logic [2:0] mode,
                              input logic sl, input logic sr, input logic sen, input logic st,
                              input logic [3:0] amt, input logic [7:0] eq, input logic eso,
                              input logic eb, input logic edn);
    vec_t v;
    v.ld = ld; v.d = d; v.mode = mode; v.sl = sl; v.sr = sr; v.sen = sen; v.st = st;
    v.amt = amt; v.eq = eq; v.eso = eso; v.eb = eb; v.edn = edn;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    bit seen;

    reset_n = 1'b0;
    {ld8, sl8, sr8, sen8, st8} = '0; d8 = '0; mode8 = '0; amt8 = '0;
    {ld16, sl16, sr16, sen16, st16} = '0; d16 = '0; mode16 = '0; amt16 = '0;

    //             ld d     md sl sr en st amt  q     so b  dn
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 3, 8'hFE, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hFC, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hF8, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hF8, 1, 0, 0));
    vecs.push_back(mk(1, 8'hA8, 0, 0, 0, 0, 0, 0, 8'hA8, 1, 0, 0));
    // ROR x8; mode changes, start and shift_en during the burst are ignored
    vecs.push_back(mk(0, 8'h00, 4, 0, 0, 0, 1, 8, 8'h54, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 1, 0, 0, 8'h2A, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 2, 8'h15, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h8A, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 2, 0, 0, 0, 0, 0, 8'h45, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hA2, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h51, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hA8, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hA8, 1, 0, 0));
    // ASR x3 on 0x80
    vecs.push_back(mk(1, 8'h80, 0, 0, 0, 0, 0, 0, 8'h80, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 5, 0, 0, 0, 1, 3, 8'hC0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hE0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hF0, 0, 0, 1));
    // amount==0
    vecs.push_back(mk(1, 8'h5A, 0, 0, 0, 0, 0, 0, 8'h5A, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 0, 1, 0, 8'h5A, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h5A, 0, 0, 0));
    // load aborts SHR x6 on third cycle
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 2, 0, 0, 0, 1, 6, 8'h7F, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h3F, 1, 1, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0, 0, 0, 0, 0, 8'h3C, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h3C, 1, 0, 0));
    // shift_en single-step SHR with ser_in_r=1
    vecs.push_back(mk(1, 8'hA8, 0, 0, 0, 0, 0, 0, 8'hA8, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 2, 0, 1, 1, 0, 0, 8'hD4, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 2, 0, 1, 1, 0, 0, 8'hEA, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 2, 0, 1, 1, 0, 0, 8'hF5, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 2, 0, 1, 1, 0, 0, 8'hFA, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 2, 0, 1, 1, 0, 0, 8'hFD, 0, 0, 0));
    // back-to-back: new start accepted while done is high
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 3, 0, 0, 0, 1, 2, 8'h02, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1, 1, 8'h04, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1, 1, 8'h09, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h09, 0, 0, 0));
    // reserved mode behaves as hold
    vecs.push_back(mk(0, 8'h00, 6, 1, 1, 1, 0, 0, 8'h09, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 7, 1, 1, 0, 1, 2, 8'h09, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h09, 0, 0, 1));

    #12;
    chk("rst_q8", 32'(q8), 32'h00);
    chk("rst_so8", 32'(so8), 32'h0);
    chk("rst_busy8", 32'(busy8), 32'h0);
    chk("rst_done8", 32'(done8), 32'h0);
    chk("rst_q16", 32'(q16), 32'hBEEF);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      ld8 = vecs[i].ld; d8 = vecs[i].d; mode8 = vecs[i].mode; sl8 = vecs[i].sl;
      sr8 = vecs[i].sr; sen8 = vecs[i].sen; st8 = vecs[i].st; amt8 = vecs[i].amt;
      tick();
      chk($sformatf("v%0d_q", i), 32'(q8), 32'(vecs[i].eq));
      chk($sformatf("v%0d_so", i), 32'(so8), 32'(vecs[i].eso));
      chk($sformatf("v%0d_busy", i), 32'(busy8), 32'(vecs[i].eb));
      chk($sformatf("v%0d_done", i), 32'(done8), 32'(vecs[i].edn));
    end

    // Reset mid-burst aborts immediately without done
    {ld8, sl8, sr8, sen8, st8} = '0; mode8 = '0; amt8 = '0;
    ld8 = 1'b1; d8 = 8'hFF;
    tick();
    ld8 = 1'b0; st8 = 1'b1; mode8 = 3'd1; amt8 = 4'd5;
    tick();
    st8 = 1'b0; mode8 = 3'd0;
    tick();
    chk("rstmid_busy_before", 32'(busy8), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_q", 32'(q8), 32'h00);
    chk("rstmid_busy", 32'(busy8), 32'h0);
    chk("rstmid_done", 32'(done8), 32'h0);
    chk("rstmid_so", 32'(so8), 32'h0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("rstmid_post_busy", 32'(busy8), 32'h0);
    chk("rstmid_post_done", 32'(done8), 32'h0);
    chk("rstmid_post_q", 32'(q8), 32'h00);

    // 16-bit ROL x4 on 0x1234
    ld16 = 1'b1; d16 = 16'h1234;
    tick();
    ld16 = 1'b0; st16 = 1'b1; mode16 = 3'd3; amt16 = 5'd4;
    tick();
    st16 = 1'b0; mode16 = 3'd0;
    chk("w16_rol1_q", 32'(q16), 32'h2468);
    chk("w16_rol1_busy", 32'(busy16), 32'h1);
    tick();
    chk("w16_rol2_q", 32'(q16), 32'h48D0);
    tick();
    chk("w16_rol3_q", 32'(q16), 32'h91A0);
    tick();
    chk("w16_rol4_q", 32'(q16), 32'h2341);
    chk("w16_rol4_done", 32'(done16), 32'h1);
    chk("w16_rol4_busy", 32'(busy16), 32'h0);

    // 16-bit SHL x16 with ser_in_l=1; done must arrive after exactly 15 more edges
    st16 = 1'b1; mode16 = 3'd1; sl16 = 1'b1; amt16 = 5'd16;
    tick();
    st16 = 1'b0; mode16 = 3'd0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (done16 === 1'b1) seen = 1'b1;
    end
    chk("w16_shl_done_seen", 32'(seen), 32'h1);
    chk("w16_shl_edges", 32'(cyc), 32'd15);
    chk("w16_shl_q", 32'(q16), 32'hFFFF);
    chk("w16_shl_so", 32'(so16), 32'h1);
    tick();
    chk("w16_shl_done_pulse", 32'(done16), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
